// File: rtl/led_bank_sched_pkg.sv
// Shared encodings and pattern tables for the LED bank scheduler.
// LED_SCHED_OVERRIDE_EN adds the OVERRIDE state.
package led_sched_pkg;

  typedef enum logic [1:0] {
    WALK   = 2'd0,
    BOUNCE = 2'd1,
    COUNT  = 2'd2,
    BLINK  = 2'd3
  } mode_e;

`ifdef LED_SCHED_OVERRIDE_EN
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    PAUSED   = 2'd1,
    OVERRIDE = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1
  } state_e;
`endif

  localparam int BOUNCE_LEN = 6;

  localparam logic [3:0][3:0] WALK_PAT = {
    4'b1000, 4'b0100, 4'b0010, 4'b0001
  };

  // Two top entries pad the table to a power of two; never reached.
  localparam logic [7:0][3:0] BOUNCE_PAT = {
    4'b0000, 4'b0000,
    4'b0010, 4'b0100, 4'b1000,
    4'b0100, 4'b0010, 4'b0001
  };

  function automatic logic [3:0] pat_of(
    mode_e m, logic [3:0] s
  );
    logic [3:0] p;
    unique case (m)
      WALK:   p = WALK_PAT[s[1:0]];
      BOUNCE: p = BOUNCE_PAT[s[2:0]];
      COUNT:  p = s;
      BLINK:  p = {4{s[0]}};
    endcase
    return p;
  endfunction

  function automatic logic [3:0] step_next(
    mode_e m, logic [3:0] s
  );
    logic [3:0] n;
    unique case (m)
      WALK:
        n = (s[1:0] == 2'd3) ? 4'd0 : s + 4'd1;
      BOUNCE:
        n = (s == 4'(BOUNCE_LEN - 1)) ? 4'd0
                                      : s + 4'd1;
      COUNT:  n = s + 4'd1;
      BLINK:  n = {3'b000, ~s[0]};
    endcase
    return n;
  endfunction

endpackage

// File: rtl/led_bank_sched_if.sv
// Control/status bundle between the top level and the LED scheduler.
// The ovr_* signals stay even when LED_SCHED_OVERRIDE_EN is undefined.
interface led_bank_sched_if;

  logic [1:0] mode_sel;
  logic       mode_load;
  logic       pause;
  logic       ovr_req;
  logic [3:0] ovr_data;
  logic       ovr_gnt;
  logic       tick;
  logic [3:0] led;

  modport master (
    output mode_sel, mode_load, pause,
    output ovr_req, ovr_data,
    input  ovr_gnt, tick, led
  );

  modport slave (
    input  mode_sel, mode_load, pause,
    input  ovr_req, ovr_data,
    output ovr_gnt, tick, led
  );

endinterface

// File: rtl/led_bank_sched_prescaler.sv
// Free-running step prescaler; tick flags the last count of each period.
// The top registers it so the output pulse lines up with the LED update.
module led_prescaler #(
  parameter int CLK_DIV = 1250000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_bank_sched.sv
// 4-LED bank scheduler: pattern engine, pause and override arbitration.
// LED_SCHED_OVERRIDE_EN enables the override requester path.
module led_bank_sched
  import led_sched_pkg::*;
#(
  parameter int CLK_DIV = 1250000
) (
  input logic             clk,
  input logic             rst,
  led_bank_sched_if.slave bus
);

  logic       pre_tick;
  state_e     state;
  state_e     state_nxt;
  mode_e      mode;
  logic [3:0] step;
  logic [3:0] pat;
  logic [3:0] pat_nxt;
  logic       adv;
  logic       gnt_nxt;
  logic       gnt_q;
  logic       tick_q;
  logic [3:0] led_q;

  led_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (pre_tick)
  );

  // Next state depends only on the request levels; override beats pause.
  always_comb begin
    state_nxt = RUN;
    gnt_nxt   = 1'b0;
    if (bus.pause) begin
      state_nxt = PAUSED;
    end
`ifdef LED_SCHED_OVERRIDE_EN
    if (bus.ovr_req) begin
      state_nxt = OVERRIDE;
      gnt_nxt   = 1'b1;
    end
`endif
    adv     = pre_tick && (state == RUN)
              && !bus.mode_load;
    pat_nxt = adv ? pat_of(mode, step) : pat;
  end

`ifndef LED_SCHED_OVERRIDE_EN
  logic unused_ovr;
  assign unused_ovr = bus.ovr_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      mode   <= WALK;
      step   <= 4'd0;
      pat    <= 4'd0;
      led_q  <= 4'd0;
      gnt_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      tick_q <= pre_tick;
      pat    <= pat_nxt;
      gnt_q  <= gnt_nxt;
      led_q  <= gnt_nxt ? bus.ovr_data : pat_nxt;
      if (bus.mode_load) begin
        mode <= mode_e'(bus.mode_sel);
        step <= 4'd0;
      end else if (adv) begin
        step <= step_next(mode, step);
      end
    end
  end

  assign bus.led     = led_q;
  assign bus.tick    = tick_q;
  assign bus.ovr_gnt = gnt_q;

endmodule

// File: tb/tb_led_bank_sched.sv
// Directed bench for led_bank_sched with a cycle model and literal checks.
// Expectations follow LED_SCHED_OVERRIDE_EN as compiled.
module tb_led_bank_sched;

  localparam int DIV = 4;
`ifdef LED_SCHED_OVERRIDE_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  led_bank_sched_if bus();

  led_bank_sched #(
    .CLK_DIV(DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Pattern as a function of advances since the last mode load.
  function automatic logic [3:0] pattern(int m, int k);
    logic [3:0] b [6];
    b = '{4'b0001, 4'b0010, 4'b0100,
          4'b1000, 4'b0100, 4'b0010};
    case (m)
      0:       return 4'(1 << (k % 4));
      1:       return b[k % 6];
      2:       return 4'(k % 16);
      default: return (k % 2 == 1) ? 4'hF : 4'h0;
    endcase
  endfunction

  int         m_cyc = 0;
  int         m_mode = 0;
  int         m_k = 0;
  bit         m_run = 1'b1;
  bit         m_valid = 1'b0;
  logic [3:0] m_pat = 4'd0;
  logic [3:0] m_led = 4'd0;
  logic       m_gnt = 1'b0;
  logic       m_tick = 1'b0;

  always @(posedge clk) begin
    bit fire;
    bit ov;
    if (rst) begin
      m_cyc = 0; m_mode = 0; m_k = 0;
      m_pat = 4'd0; m_led = 4'd0;
      m_gnt = 1'b0; m_tick = 1'b0;
      m_run = 1'b1;
    end else begin
      m_cyc++;
      fire = (m_cyc % DIV == 0);
      if (bus.mode_load) begin
        m_mode = int'(bus.mode_sel);
        m_k = 0;
      end else if (fire && m_run) begin
        m_pat = pattern(m_mode, m_k);
        m_k++;
      end
      ov     = OVR && bus.ovr_req;
      m_gnt  = ov;
      m_led  = ov ? bus.ovr_data : m_pat;
      m_tick = fire;
      m_run  = !ov && !bus.pause;
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_tick", {3'b0, bus.tick}, {3'b0, m_tick});
      chk("model_gnt", {3'b0, bus.ovr_gnt}, {3'b0, m_gnt});
      chk("model_led", bus.led, m_led);
    end
  end

  task automatic wait_tick(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 2 * DIV && !seen; i++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: got no tick want tick", name);
    end
  endtask

  task automatic load(input logic [1:0] sel);
    bus.mode_sel  = sel;
    bus.mode_load = 1'b1;
    @(negedge clk);
    bus.mode_load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] walk_e [4];
    logic [3:0] bnc_e [8];
    logic [3:0] l_after;
    walk_e = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bnc_e  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
               4'b0100, 4'b0010, 4'b0001, 4'b0010};
    bus.mode_sel  = 2'd0;
    bus.mode_load = 1'b0;
    bus.pause     = 1'b0;
    bus.ovr_req   = 1'b0;
    bus.ovr_data  = 4'd0;

    repeat (3) @(negedge clk);
    chk("rst_led", bus.led, 4'b0000);
    chk("rst_gnt", {3'b0, bus.ovr_gnt}, 4'd0);
    chk("rst_tick", {3'b0, bus.tick}, 4'd0);
    rst = 1'b0;

    for (int i = 1; i <= DIV; i++) begin
      @(negedge clk);
      if (i < DIV) begin
        chk("first_tick_early", {3'b0, bus.tick}, 4'd0);
      end else begin
        chk("first_tick", {3'b0, bus.tick}, 4'd1);
        chk("first_led", bus.led, 4'b0001);
      end
    end
    foreach (walk_e[i]) begin
      wait_tick("walk");
      chk("walk_led", bus.led, walk_e[i]);
    end

    load(2'd1);
    foreach (bnc_e[i]) begin
      wait_tick("bounce");
      chk("bounce_led", bus.led, bnc_e[i]);
    end

    load(2'd2);
    for (int i = 0; i <= 16; i++) begin
      wait_tick("count");
      chk("count_led", bus.led, 4'(i));
    end

    load(2'd0);
    wait_tick("walk2");
    chk("walk2_led", bus.led, 4'b0001);
    wait_tick("walk2");
    chk("walk2_led", bus.led, 4'b0010);
    wait_tick("walk2");
    chk("walk2_led", bus.led, 4'b0100);
    bus.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_tick("paused");
      chk("paused_led", bus.led, 4'b0100);
    end
    bus.pause = 1'b0;
    wait_tick("unpause");
    chk("unpause_led", bus.led, 4'b1000);

    wait_tick("walk3");
    chk("walk3_led", bus.led, 4'b0001);
    wait_tick("walk3");
    chk("walk3_led", bus.led, 4'b0010);
    bus.ovr_data = 4'b1010;
    bus.ovr_req  = 1'b1;
    @(negedge clk);
    chk("ovr_gnt", {3'b0, bus.ovr_gnt}, {3'b0, OVR});
    chk("ovr_led", bus.led, OVR ? 4'b1010 : 4'b0010);
    repeat (9) @(negedge clk);
    bus.ovr_req = 1'b0;
    @(negedge clk);
    chk("rel_gnt", {3'b0, bus.ovr_gnt}, 4'd0);
    chk("rel_led", bus.led, OVR ? 4'b0010 : 4'b1000);
    l_after = OVR ? 4'b0100 : 4'b0001;
    wait_tick("rel_tick");
    chk("rel_tick_led", bus.led, l_after);

    repeat (3) @(negedge clk);
    bus.mode_sel  = 2'd3;
    bus.mode_load = 1'b1;
    @(negedge clk);
    bus.mode_load = 1'b0;
    chk("ld_tick", {3'b0, bus.tick}, 4'd1);
    chk("ld_tick_led", bus.led, l_after);
    wait_tick("blink");
    chk("blink_led", bus.led, 4'b0000);
    wait_tick("blink");
    chk("blink_led", bus.led, 4'b1111);
    wait_tick("blink");
    chk("blink_led", bus.led, 4'b0000);

    repeat (3) @(negedge clk);
    bus.pause = 1'b1;
    @(negedge clk);
    chk("pause_edge_tick", {3'b0, bus.tick}, 4'd1);
    chk("pause_edge_led", bus.led, 4'b1111);
    bus.pause = 1'b0;
    wait_tick("after_pause_edge");
    chk("after_pause_led", bus.led, 4'b0000);

    bus.ovr_data = 4'b0110;
    bus.ovr_req  = 1'b1;
    @(negedge clk);
    chk("ovr2_gnt", {3'b0, bus.ovr_gnt}, {3'b0, OVR});
    chk("ovr2_led", bus.led, OVR ? 4'b0110 : 4'b0000);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ovr_gnt", {3'b0, bus.ovr_gnt}, 4'd0);
    chk("rst_ovr_led", bus.led, 4'b0000);
    rst = 1'b0;
    bus.ovr_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_bank_sched.md
# led_bank_sched

Scheduler/controller for the 4-LED bank on the OpenEP4CE6-C board. It divides the board clock into a step tick and sequences one of four display patterns: walk, bounce, binary count or blink. It also arbitrates the bank between the pattern engine and an external override requester (for example a status or debug source). It sits between the top level and the `led[3:0]` pins and replaces ad-hoc per-demo LED drivers.

## Interface
- `CLK_DIV`, 1250000: clk cycles per step tick; legal values are ≥ 2.
- `clk`  in  1  board clock; the only clock in the block.
- `rst`  in  1  reset: synchronous, active-high.
- `mode_sel`  in  2  pattern to load: 0 walk, 1 bounce, 2 count, 3 blink.
- `mode_load`  in  1  single-cycle strobe that applies `mode_sel`.
- `pause`  in  1  level; freezes pattern advance while high.
- `ovr_req`  in  1  level; override requester asks for the bank.
- `ovr_data`  in  4  LED value to display while granted.
- `ovr_gnt`  out  1  override currently owns the bank.
- `tick`  out  1  one-cycle pulse per step period.
- `led`  out  4  registered LED drive; 1 = on.

## Operation
- Prescaler `cnt` runs 0..CLK_DIV-1 and is free-running in every state.
  - On the edge where `cnt == CLK_DIV-1`: `cnt` → 0 and `tick` → 1 for one cycle.
- FSM states: RUN, PAUSED, OVERRIDE.
  - RUN → PAUSED when `pause` = 1; PAUSED → RUN when `pause` = 0.
  - RUN or PAUSED → OVERRIDE when `ovr_req` = 1. Override has priority over pause.
  - OVERRIDE → RUN or PAUSED, chosen by the current `pause`, when `ovr_req` = 0.
- Pattern engine holds `mode`, a 3-bit `step`, and a 4-bit `pat` register.
- On a tick in RUN, `pat` takes the value of `step`, then `step` advances:
  - walk: 0001, 0010, 0100, 1000, then wraps (step 0..3).
  - bounce: 0001, 0010, 0100, 1000, 0100, 0010, then wraps (step 0..5).
  - count: `pat` = step counter, 4 bits, 0000..1111, wraps 1111 → 0000. For this mode `step` is extended to a 4-bit counter.
  - blink: 0000, 1111, alternating.
- `mode_load`: `mode` ← `mode_sel` and `step` ← 0 on the next edge, in any state. `pat` is unchanged until the next RUN tick, which shows step 0 of the new mode.
- In PAUSED and OVERRIDE, `step` and `pat` are frozen. Ticks still pulse.
- Output `led` is driven by state:
  - RUN and PAUSED: `led` = `pat`.
  - OVERRIDE: `led` = `ovr_data`, registered every cycle.
- Boundary cases:
  - A tick on the same edge as `mode_load`: the load wins; `step` = 0 and no advance happens.
  - A tick on the same edge as the transition into PAUSED or OVERRIDE: the advance still happens, because RUN was the state sampled.
  - `rst` mid-override: `ovr_gnt` drops to 0 on that edge.

## Timing
- Reset values:
  - `cnt` = 0, `tick` = 0, `mode` = 0, `step` = 0, `pat` = 0000.
  - `led` = 0000, `ovr_gnt` = 0, state = RUN.
- First tick comes CLK_DIV cycles after `rst` deasserts. On that tick `led` = 0001 (walk, step 0).
- Tick-to-LED latency is 0: the new `led` value and `tick` = 1 appear together on the same edge.
- Override grant: `ovr_req` seen high at edge N gives `ovr_gnt` = 1 and `led` = `ovr_data`(N) after edge N. Release has the same 1-cycle latency, and `led` returns to the frozen `pat`.
- `pause` and `mode_load` take effect with 1-cycle latency.
- No combinational paths from inputs to outputs.

## Configuration
- `LED_SCHED_OVERRIDE_EN` defined: the OVERRIDE state, the `ovr_*` logic and the grant behaviour above are present.
- `LED_SCHED_OVERRIDE_EN` undefined:
  - The OVERRIDE state is removed and `ovr_req` / `ovr_data` are ignored.
  - `ovr_gnt` is tied to 0.
  - The ports remain so the top level is unchanged.

## Structure
- Package `led_sched_pkg` holds:
  - the mode encodings (WALK, BOUNCE, COUNT, BLINK);
  - the FSM state encoding;
  - the walk and bounce pattern constants, with bounce length 6.
- One sub-module, `led_prescaler`: parameter CLK_DIV, ports `clk`, `rst`, `tick`. The top instantiates it once.
- The FSM, pattern engine and output mux live in `led_bank_sched`.

## Test plan
All scenarios use CLK_DIV = 4 and `LED_SCHED_OVERRIDE_EN` defined unless stated otherwise.
- Reset, then walk mode: ticks at cycles 4, 8, 12, 16, 20 → `led` = 0001, 0010, 0100, 1000, 0001.
- `mode_load` with `mode_sel` = 1: 8 ticks → 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- Count mode: 17 ticks → 0000..1111, then 0000 (wrap).
- `pause` high for 3 ticks mid-walk at `led` = 0100: `led` holds 0100. After release the next tick gives 1000, and `tick` pulses throughout.
- `ovr_req` = 1 with `ovr_data` = 1010 for 10 cycles in walk at `led` = 0010:
  - `ovr_gnt` and `led` = 1010 appear one cycle after the request.
  - After release, `led` = 0010 one cycle later, and the next tick gives 0100.
- Macro undefined: same stimulus as the previous scenario → `ovr_gnt` stays 0 and the walk continues unaffected.
